// File: rtl/elevator_scan_controller_if.sv
// Request and indicator bundle between the hall/car buttons and the elevator car controller.
// The controller takes the slave side; the button panel / indicator side takes the master side.
interface elevator_scan_controller_if #(
  parameter int unsigned NUM_FLOORS = 5
);
  logic [NUM_FLOORS-1:0] floor_req;
  logic [NUM_FLOORS-1:0] floor_pos;
  logic                  dir_up;
  logic                  moving;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output floor_req,
    input  floor_pos,
    input  dir_up,
    input  moving,
    input  door_open,
    input  pending
  );

  modport slave (
    input  floor_req,
    output floor_pos,
    output dir_up,
    output moving,
    output door_open,
    output pending
  );
endinterface

// File: rtl/elevator_scan_controller.sv
// SCAN-order elevator car controller: latches floor requests, keeps travelling while requests
// remain ahead, reverses through IDLE, and holds the door open for a fixed dwell at each stop.
module elevator_scan_controller #(
  parameter int unsigned NUM_FLOORS  = 5,
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES = 3
) (
  input logic                       clk,
  input logic                       reset,
  elevator_scan_controller_if.slave bus
);

  localparam int unsigned CntMax = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = $clog2(NUM_FLOORS);

  localparam logic [CntW-1:0]       MoveLast = CntW'(MOVE_CYCLES - 1);
  localparam logic [CntW-1:0]       DoorLast = CntW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] Floor0Oh = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  dir_q, dir_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;

  logic [IdxW-1:0]       next_idx;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [NUM_FLOORS-1:0] ahead, behind, ahead_next;

  // Floors strictly above (up=1) or strictly below (up=0) the given floor.
  function automatic logic [NUM_FLOORS-1:0] side_mask(input logic [IdxW-1:0] idx, input logic up);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      m[i] = up ? (i > int'(idx)) : (i < int'(idx));
    end
    return m;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    clear_mask = '0;
    next_idx   = dir_q ? (idx_q + IdxW'(1)) : (idx_q - IdxW'(1));
    ahead      = pend_q & side_mask(idx_q, dir_q);
    behind     = pend_q & side_mask(idx_q, !dir_q);
    ahead_next = pend_q & side_mask(next_idx, dir_q);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pend_q[idx_q]) begin
          state_d    = StDoor;
          clear_mask = Floor0Oh << idx_q;
        end else if (|ahead) begin
          state_d = StMove;
        end else if (|behind) begin
          dir_d   = !dir_q;
          state_d = StMove;
        end
      end
      StMove: begin
        if (cnt_q == MoveLast) begin
          idx_d = next_idx;
          cnt_d = '0;
          // Arrival decision uses pending as registered before this edge.
          if (pend_q[next_idx]) begin
            state_d    = StDoor;
            clear_mask = Floor0Oh << next_idx;
          end else if (!(|ahead_next)) begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDoor: begin
        clear_mask = Floor0Oh << idx_q;
        if (cnt_q == DoorLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    pend_d = (pend_q | bus.floor_req) & ~clear_mask;
  end

  always_comb begin
    bus.floor_pos = Floor0Oh << idx_q;
    bus.dir_up    = dir_q;
    bus.moving    = (state_q == StMove);
    bus.door_open = (state_q == StDoor);
    bus.pending   = pend_q;
  end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: directed SCAN scenarios plus random request sets checked
// against an event-level model that predicts which floors open and on which edge.
module tb_elevator_scan_controller;

  localparam int NfA = 5;
  localparam int MvA = 4;
  localparam int DrA = 3;
  localparam int NfB = 8;
  localparam int MvB = 1;
  localparam int DrB = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int checks   = 0;
  int failures = 0;

  int obs_floor[$];
  int obs_rise[$];
  int obs_fall[$];
  int exp_floor[$];
  int exp_edge[$];
  bit saw_move;

  elevator_scan_controller_if #(.NUM_FLOORS(NfA)) a_if ();
  elevator_scan_controller_if #(.NUM_FLOORS(NfB)) b_if ();

  elevator_scan_controller #(
    .NUM_FLOORS (NfA),
    .MOVE_CYCLES(MvA),
    .DOOR_CYCLES(DrA)
  ) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (a_if.slave)
  );

  elevator_scan_controller #(
    .NUM_FLOORS (NfB),
    .MOVE_CYCLES(MvB),
    .DOOR_CYCLES(DrB)
  ) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (b_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset == 1'b0) begin
      assert ($onehot(a_if.floor_pos)) else $error("FAIL onehot_a floor_pos=%b", a_if.floor_pos);
      assert ($onehot(b_if.floor_pos)) else $error("FAIL onehot_b floor_pos=%b", b_if.floor_pos);
      assert (!(a_if.moving && a_if.door_open))
        else $error("FAIL exclusive_a moving=%b door_open=%b", a_if.moving, a_if.door_open);
      assert (!(b_if.moving && b_if.door_open))
        else $error("FAIL exclusive_b moving=%b door_open=%b", b_if.moving, b_if.door_open);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int oh_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    a_if.floor_req = '0;
    b_if.floor_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Drives req on relative edge 0 (and extra on extra_edge), records door-open intervals of DUT A.
  task automatic watch_a(input logic [NfA-1:0] req, input logic [NfA-1:0] extra,
                         input int extra_edge, input int budget);
    bit prev;
    obs_floor.delete();
    obs_rise.delete();
    obs_fall.delete();
    saw_move = 1'b0;
    prev = a_if.door_open;
    for (int n = 0; n < budget; n++) begin
      a_if.floor_req = (n == 0) ? req : ((n == extra_edge) ? extra : '0);
      @(negedge clk);
      if (a_if.moving) saw_move = 1'b1;
      if (a_if.door_open && !prev) begin
        obs_floor.push_back(oh_idx(8'(a_if.floor_pos)));
        obs_rise.push_back(n);
      end
      if (!a_if.door_open && prev) obs_fall.push_back(n);
      prev = a_if.door_open;
    end
    a_if.floor_req = '0;
  endtask

  // Event-level SCAN model for an idle car with an empty pending set receiving req at edge 0.
  task automatic model_scan(input logic [NfA-1:0] req, inout int f, inout bit up, output int last);
    logic [NfA-1:0] r;
    int e;
    int tgt;
    bit fwd;
    exp_floor.delete();
    exp_edge.delete();
    r = req;
    e = 1;
    last = 0;
    while (r != '0) begin
      if (r[f]) begin
        exp_floor.push_back(f);
        exp_edge.push_back(e);
        last = e;
        r[f] = 1'b0;
        e = e + DrA + 1;
      end else begin
        fwd = 1'b0;
        for (int i = 0; i < NfA; i++) if (r[i] && (up ? (i > f) : (i < f))) fwd = 1'b1;
        if (!fwd) up = !up;
        tgt = f;
        do begin
          tgt = up ? tgt + 1 : tgt - 1;
        end while (!r[tgt]);
        e = e + (up ? tgt - f : f - tgt) * MvA;
        exp_floor.push_back(tgt);
        exp_edge.push_back(e);
        last = e;
        r[tgt] = 1'b0;
        f = tgt;
        e = e + DrA + 1;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_if.floor_pos !== 5'b00001) begin failures++;
      $display("FAIL reset_floor_pos got=%b want=00001", a_if.floor_pos); end
    checks++; if (a_if.dir_up !== 1'b1) begin failures++;
      $display("FAIL reset_dir_up got=%b want=1", a_if.dir_up); end
    checks++; if (a_if.moving !== 1'b0 || a_if.door_open !== 1'b0) begin failures++;
      $display("FAIL reset_idle moving=%b door_open=%b want=0/0", a_if.moving, a_if.door_open); end
    checks++; if (a_if.pending !== 5'b00000) begin failures++;
      $display("FAIL reset_pending got=%b want=00000", a_if.pending); end
    checks++; if (b_if.floor_pos !== 8'h01 || b_if.pending !== 8'h00) begin failures++;
      $display("FAIL reset_b floor_pos=%h pending=%h want=01/00", b_if.floor_pos, b_if.pending); end
  endtask

  task automatic test_single_request();
    do_reset();
    watch_a(5'b00100, '0, -1, 16);
    checks++; if (obs_rise.size() != 1) begin failures++;
      $display("FAIL single_stops got=%0d want=1", obs_rise.size()); end
    else begin
      checks++; if (obs_floor[0] != 2 || obs_rise[0] != 9) begin failures++;
        $display("FAIL single_arrival got floor=%0d edge=%0d want floor=2 edge=9",
                 obs_floor[0], obs_rise[0]); end
      checks++; if (((obs_fall.size() == 0) ? -1 : obs_fall[0]) != 12) begin failures++;
        $display("FAIL single_door_close got=%0d want=12",
                 (obs_fall.size() == 0) ? -1 : obs_fall[0]); end
    end
    checks++; if (a_if.pending !== 5'b00000 || a_if.floor_pos !== 5'b00100) begin failures++;
      $display("FAIL single_final pending=%b floor_pos=%b want 00000/00100",
               a_if.pending, a_if.floor_pos); end
  endtask

  task automatic test_same_floor();
    do_reset();
    watch_a(5'b00001, '0, -1, 8);
    checks++; if (obs_rise.size() != 1 || obs_floor[0] != 0 || obs_rise[0] != 1) begin failures++;
      $display("FAIL same_floor_door got stops=%0d want one stop at floor 0 edge 1", obs_rise.size());
    end
    checks++; if (((obs_fall.size() == 0) ? -1 : obs_fall[0]) != 4) begin failures++;
      $display("FAIL same_floor_close got=%0d want=4", (obs_fall.size() == 0) ? -1 : obs_fall[0]); end
    checks++; if (saw_move !== 1'b0) begin failures++;
      $display("FAIL same_floor_moving got=%b want=0", saw_move); end
  endtask

  task automatic test_reverse();
    do_reset();
    exp_floor = '{4, 1, 0};
    exp_edge  = '{17, 33, 41};
    watch_a(5'b10000, 5'b00011, 10, 48);
    checks++; if (obs_rise.size() != exp_edge.size()) begin failures++;
      $display("FAIL reverse_stops got=%0d want=%0d", obs_rise.size(), exp_edge.size()); end
    for (int i = 0; i < exp_edge.size() && i < obs_rise.size(); i++) begin
      checks++;
      if (obs_floor[i] != exp_floor[i] || obs_rise[i] != exp_edge[i] ||
          ((i < obs_fall.size()) ? obs_fall[i] : -1) != exp_edge[i] + DrA) begin
        failures++;
        $display("FAIL reverse_stop%0d got floor=%0d open=%0d close=%0d want %0d/%0d/%0d", i,
                 obs_floor[i], obs_rise[i], (i < obs_fall.size()) ? obs_fall[i] : -1,
                 exp_floor[i], exp_edge[i], exp_edge[i] + DrA);
      end
    end
    checks++; if (a_if.dir_up !== 1'b0 || a_if.pending !== 5'b00000) begin failures++;
      $display("FAIL reverse_final dir_up=%b pending=%b want 0/00000", a_if.dir_up, a_if.pending); end
  endtask

  task automatic test_pass_through();
    do_reset();
    exp_floor = '{2, 4};
    exp_edge  = '{9, 21};
    watch_a(5'b10000, 5'b00100, 6, 28);
    checks++; if (obs_rise.size() != exp_edge.size()) begin failures++;
      $display("FAIL pass_stops got=%0d want=%0d", obs_rise.size(), exp_edge.size()); end
    for (int i = 0; i < exp_edge.size() && i < obs_rise.size(); i++) begin
      checks++;
      if (obs_floor[i] != exp_floor[i] || obs_rise[i] != exp_edge[i] ||
          ((i < obs_fall.size()) ? obs_fall[i] : -1) != exp_edge[i] + DrA) begin
        failures++;
        $display("FAIL pass_stop%0d got floor=%0d open=%0d close=%0d want %0d/%0d/%0d", i,
                 obs_floor[i], obs_rise[i], (i < obs_fall.size()) ? obs_fall[i] : -1,
                 exp_floor[i], exp_edge[i], exp_edge[i] + DrA);
      end
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    watch_a(5'b10000, '0, -1, 11);
    checks++; if (a_if.floor_pos !== 5'b00100 || a_if.moving !== 1'b1) begin failures++;
      $display("FAIL midmove_premise floor_pos=%b moving=%b want 00100/1", a_if.floor_pos,
               a_if.moving); end
    #2 reset = 1'b1;
    #1;
    checks++; if (a_if.floor_pos !== 5'b00001) begin failures++;
      $display("FAIL midmove_floor_pos got=%b want=00001", a_if.floor_pos); end
    checks++; if (a_if.moving !== 1'b0 || a_if.door_open !== 1'b0) begin failures++;
      $display("FAIL midmove_idle moving=%b door_open=%b want 0/0", a_if.moving, a_if.door_open); end
    checks++; if (a_if.pending !== 5'b00000 || a_if.dir_up !== 1'b1) begin failures++;
      $display("FAIL midmove_pending_dir pending=%b dir_up=%b want 00000/1", a_if.pending,
               a_if.dir_up); end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (a_if.floor_pos !== 5'b00001 || a_if.moving !== 1'b0) begin failures++;
      $display("FAIL midmove_after floor_pos=%b moving=%b want 00001/0", a_if.floor_pos,
               a_if.moving); end
  endtask

  task automatic test_wide_top();
    int first_top;
    int open_edge;
    bit bad;
    do_reset();
    first_top = -1;
    open_edge = -1;
    bad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      b_if.floor_req = (n == 0) ? 8'h80 : 8'h00;
      @(negedge clk);
      if (b_if.floor_pos == 8'h80 && first_top < 0) first_top = n;
      if (b_if.door_open && open_edge < 0) open_edge = n;
      if (!$onehot(b_if.floor_pos)) bad = 1'b1;
    end
    b_if.floor_req = '0;
    checks++; if (first_top != 8 || open_edge != 8) begin failures++;
      $display("FAIL wide_arrival got top=%0d open=%0d want 8/8", first_top, open_edge); end
    checks++; if (bad !== 1'b0) begin failures++;
      $display("FAIL wide_onehot got=%b want=0", bad); end
    checks++; if (b_if.floor_pos !== 8'h80 || b_if.pending !== 8'h00 || b_if.moving !== 1'b0) begin
      failures++;
      $display("FAIL wide_final floor_pos=%h pending=%h moving=%b want 80/00/0", b_if.floor_pos,
               b_if.pending, b_if.moving); end
  endtask

  task automatic test_random_scan();
    int f;
    bit up;
    int last;
    logic [NfA-1:0] req;
    do_reset();
    f = 0;
    up = 1'b1;
    for (int it = 0; it < 12; it++) begin
      req = NfA'($urandom_range(1, (1 << NfA) - 1));
      model_scan(req, f, up, last);
      watch_a(req, '0, -1, last + DrA + 4);
      checks++; if (obs_rise.size() != exp_edge.size()) begin failures++;
        $display("FAIL random%0d_stops req=%b got=%0d want=%0d", it, req, obs_rise.size(),
                 exp_edge.size()); end
      for (int i = 0; i < exp_edge.size() && i < obs_rise.size(); i++) begin
        checks++;
        if (obs_floor[i] != exp_floor[i] || obs_rise[i] != exp_edge[i] ||
            ((i < obs_fall.size()) ? obs_fall[i] : -1) != exp_edge[i] + DrA) begin
          failures++;
          $display("FAIL random%0d_stop%0d req=%b got floor=%0d open=%0d close=%0d want %0d/%0d/%0d",
                   it, i, req, obs_floor[i], obs_rise[i], (i < obs_fall.size()) ? obs_fall[i] : -1,
                   exp_floor[i], exp_edge[i], exp_edge[i] + DrA);
        end
      end
      checks++;
      if (a_if.pending !== 5'b00000 || oh_idx(8'(a_if.floor_pos)) != f || a_if.dir_up !== up) begin
        failures++;
        $display("FAIL random%0d_final pending=%b floor=%0d dir_up=%b want 00000/%0d/%b", it,
                 a_if.pending, oh_idx(8'(a_if.floor_pos)), a_if.dir_up, f, up);
      end
    end
  endtask

  initial begin
    a_if.floor_req = '0;
    b_if.floor_req = '0;
    test_reset();
    test_single_request();
    test_same_floor();
    test_reverse();
    test_pass_through();
    test_reset_mid_move();
    test_wide_top();
    test_random_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_scan_controller.md
# elevator_scan_controller

Parametrised elevator car controller for NUM_FLOORS floors. It latches hall and car requests into a pending set and serves them in SCAN order: it keeps moving in one direction while requests remain ahead, then reverses. Floor travel time and door dwell time are counted in clock cycles. It sits between the request inputs (buttons) and the position/door indicators, and is the generalised successor to the fixed 5-floor controller.

## Interface
- NUM_FLOORS, 5, number of floors; legal range is 2 or more; floor 0 is the bottom floor.
- MOVE_CYCLES, 4, cycles to travel one floor; legal range is 1 or more.
- DOOR_CYCLES, 3, cycles the door stays open at a served floor; legal range is 1 or more.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- floor_req  in  NUM_FLOORS  level request, one bit per floor; any set bit is OR'd into pending on each edge.
- floor_pos  out  NUM_FLOORS  one-hot current floor.
- dir_up  out  1  current travel direction: 1 is up, 0 is down.
- moving  out  1  high while in the MOVE state.
- door_open  out  1  high while in the DOOR state.
- pending  out  NUM_FLOORS  latched, not-yet-served requests.

## Operation
- States: IDLE, MOVE, DOOR. One counter is shared by MOVE and DOOR. Its width is $clog2(max(MOVE_CYCLES,DOOR_CYCLES)+1).
- Pending update on every edge: pending <= (pending | floor_req) & ~clear_mask.
  - In DOOR, clear_mask is the current floor, so requests for the open floor are dropped.
  - Outside DOOR, clear_mask is the entry-to-DOOR floor on the entry edge, and 0 otherwise.
- Define "ahead" as pending bits strictly above the current floor (when dir_up=1) or strictly below it (when dir_up=0). Define "behind" as the opposite side.
- IDLE decision, taken each cycle from the registered pending:
  - If pending has the current floor set → DOOR, counter cleared, current bit cleared.
  - Else if ahead is non-empty → MOVE, direction unchanged.
  - Else if behind is non-empty → toggle dir_up, then MOVE.
  - Else stay in IDLE.
- MOVE:
  - The counter increments each cycle.
  - On the MOVE_CYCLES-th edge in MOVE, floor_pos shifts one floor in dir_up, the counter clears, and the arrival decision is taken from pending as registered before that edge:
    - If pending has the new floor set → DOOR (bit cleared).
    - Else if ahead of the new floor is non-empty → remain in MOVE.
    - Else → IDLE.
- DOOR: door_open=1 for exactly DOOR_CYCLES cycles, then IDLE.
- Limits: the car never moves past floor 0 or floor NUM_FLOORS-1. At the top, "ahead" for up is empty by construction, so the direction reverses via IDLE.
- Requests raised mid-travel for an intermediate floor in the current direction are served on the way. A request for the floor being arrived at, raised on the arrival edge itself, is not stopped for; it is served on the return pass.

## Timing
- Reset values: floor_pos = 1 (floor 0), dir_up=1, moving=0, door_open=0, pending=0, state IDLE, counter=0. Reset takes effect immediately and asynchronously, including mid-MOVE or mid-DOOR. The car returns to floor 0 with no motion.
- Request at edge t → pending visible after t. IDLE → MOVE at edge t+1. First floor change at t+1+MOVE_CYCLES.
- Request at a distance of d floors from an idle car: door_open rises at edge t+1+d·MOVE_CYCLES and stays high for DOOR_CYCLES cycles. IDLE is re-entered at t+1+d·MOVE_CYCLES+DOOR_CYCLES.
- After DOOR, IDLE always costs at least one cycle before the next MOVE or DOOR.
- moving and door_open are never high together.
- floor_pos is always exactly one-hot.
- Simultaneous requests on multiple floors are all latched in the same cycle.

## Test plan
- Reset, then floor_req=5'b00100 for 1 cycle at edge t (MOVE_CYCLES=4, DOOR_CYCLES=3) → floor_pos reaches 5'b00100 at t+9, door_open high for t+9..t+11, pending=0, IDLE at t+12.
- Idle at floor 0, floor_req=5'b00001 → no motion; door_open high for 3 cycles starting at t+1; moving stays 0.
- At floor 2 moving up toward floor 4, assert floor_req=5'b00011 during travel → the car serves floor 4, toggles dir_up to 0 in IDLE, then serves floor 1 and then floor 0 in descending order.
- Request floor 4 from floor 0, then assert floor_req=5'b00100 while passing floor 1 → the car stops at floor 2 (door_open), then continues to floor 4.
- Reset asserted mid-MOVE between floors 2 and 3 → same cycle: floor_pos=5'b00001, moving=0, pending=0, dir_up=1.
- NUM_FLOORS=8, MOVE_CYCLES=1, DOOR_CYCLES=1, floor_req=8'h80 → the car reaches floor 7 at t+8 and never exceeds floor 7. floor_pos stays one-hot throughout (checked by assertion).
